mcu_irq_arbiter: RTL and testbench

Shares the single MCU interrupt line and the MCU byte channel between up to eight core-side service requesters (HID, OSD, SD card, system). It latches request pulses, drives an active-low interrupt to the MCU while any enabled request is pending, and, when the MCU addresses it as a byte-channel target, hands out round-robin grants and acknowledges the granted source. It sits beside the SPI byte-channel front end, as one more target on that channel.

---
 rtl/mcu_pkg.sv | 17 +
 rtl/rr_pick.sv | 29 ++
 rtl/mcu_irq_arbiter.sv | 127 ++++++++++++
 tb/tb_mcu_irq_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared constants and types for the MCU byte-channel interrupt arbiter.
package mcu_pkg;

   localparam logic [7:0] MCU_CMD_GRANT   = 8'h01;
   localparam logic [7:0] MCU_CMD_PENDING = 8'h02;
   localparam logic [7:0] MCU_CMD_MASK    = 8'h03;

   localparam logic [7:0] MCU_TARGET_IRQ  = 8'd4;

   localparam int unsigned GRANT_VALID = 7;

   typedef enum logic {
      StIdle   = 1'b0,
      StMaskWr = 1'b1
   } mcu_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request above rr_last, wrapping at N.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   rr_last,
   output logic         found,
   output logic [2:0]   index
);

   always_comb begin
      found = 1'b0;
      index = 3'd0;
      // Upper segment (after rr_last) has priority over the wrapped lower segment.
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i > int'(rr_last))) begin
            found = 1'b1;
            index = 3'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i <= int'(rr_last))) begin
            found = 1'b1;
            index = 3'(i);
         end
      end
   end

endmodule

// File: rtl/mcu_irq_arbiter.sv
// Latches service requests, drives the MCU interrupt, and serves GRANT/PENDING/MASK
// commands as a byte-channel target.
module mcu_irq_arbiter
   import mcu_pkg::*;
#(
   parameter int unsigned N_SRC   = 4,
   parameter int unsigned HOLDOFF = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] src_req,
   output logic [N_SRC-1:0] src_ack,
   output logic             irq_n,
   input  logic             mcu_strobe,
   input  logic             mcu_start,
   input  logic [7:0]       mcu_din,
   output logic [7:0]       mcu_dout
);

   mcu_state_e       state_q, state_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] enable_q, enable_d;
   logic [2:0]       rr_last_q, rr_last_d;
   logic [N_SRC-1:0] src_ack_q, src_ack_d;
   logic             irq_n_q, irq_n_d;
   logic [7:0]       dout_q, dout_d;
   logic [7:0]       hold_q, hold_d;

   logic             cmd_strobe;
   logic             data_strobe;
   logic             pick_found;
   logic [2:0]       pick_index;
   logic             grant;
   logic [N_SRC-1:0] grant_vec;

   rr_pick #(
      .N (N_SRC)
   ) u_rr_pick (
      .req     (pending_q & enable_q),
      .rr_last (rr_last_q),
      .found   (pick_found),
      .index   (pick_index)
   );

   assign cmd_strobe  = mcu_strobe && mcu_start;
   assign data_strobe = mcu_strobe && !mcu_start;
   assign grant       = cmd_strobe && (mcu_din == MCU_CMD_GRANT) && pick_found;

   always_comb begin
      grant_vec = '0;
      for (int i = 0; i < N_SRC; i++) begin
         grant_vec[i] = grant && (pick_index == 3'(i));
      end
   end

   always_comb begin
      state_d  = state_q;
      enable_d = enable_q;
      dout_d   = dout_q;

      if (cmd_strobe) begin
         state_d = StIdle;
         dout_d  = 8'h00;
         unique case (mcu_din)
            MCU_CMD_GRANT: begin
               if (pick_found) begin
                  dout_d[GRANT_VALID] = 1'b1;
                  dout_d[2:0]         = pick_index;
               end
            end
            MCU_CMD_PENDING: dout_d[N_SRC-1:0] = pending_q;
            MCU_CMD_MASK: begin
               dout_d[N_SRC-1:0] = enable_q;
               state_d           = StMaskWr;
            end
            default: ;
         endcase
      end else if (data_strobe && (state_q == StMaskWr)) begin
         enable_d = mcu_din[N_SRC-1:0];
         state_d  = StIdle;
      end
   end

   // A request arriving in the grant cycle survives the clear.
   assign pending_d = (pending_q & ~grant_vec) | src_req;
   assign src_ack_d = grant_vec;
   assign rr_last_d = grant ? pick_index : rr_last_q;

   always_comb begin
      if (grant) begin
         hold_d = 8'(HOLDOFF);
      end else if (hold_q != 8'd0) begin
         hold_d = hold_q - 8'd1;
      end else begin
         hold_d = 8'd0;
      end
   end

   assign irq_n_d = !(((pending_d & enable_d) != '0) && (hold_d == 8'd0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         pending_q <= '0;
         enable_q  <= '1;
         rr_last_q <= 3'(N_SRC - 1);
         src_ack_q <= '0;
         irq_n_q   <= 1'b1;
         dout_q    <= 8'h00;
         hold_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         rr_last_q <= rr_last_d;
         src_ack_q <= src_ack_d;
         irq_n_q   <= irq_n_d;
         dout_q    <= dout_d;
         hold_q    <= hold_d;
      end
   end

   assign src_ack  = src_ack_q;
   assign irq_n    = irq_n_q;
   assign mcu_dout = dout_q;

endmodule

// File: tb/tb_mcu_irq_arbiter.sv
// Directed self-checking bench for mcu_irq_arbiter (N_SRC=4, HOLDOFF=16).
module tb_mcu_irq_arbiter;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] src_req = '0;
   logic [N-1:0] src_ack;
   logic         irq_n;
   logic         mcu_strobe = 1'b0;
   logic         mcu_start = 1'b0;
   logic [7:0]   mcu_din = 8'h00;
   logic [7:0]   mcu_dout;

   int checks = 0;
   int errors = 0;

   mcu_irq_arbiter #(
      .N_SRC   (N),
      .HOLDOFF (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .src_req    (src_req),
      .src_ack    (src_ack),
      .irq_n      (irq_n),
      .mcu_strobe (mcu_strobe),
      .mcu_start  (mcu_start),
      .mcu_din    (mcu_din),
      .mcu_dout   (mcu_dout)
   );

   always #5 clk = ~clk;

   // Stimulus helpers: start and end on a falling edge, so outputs are stable on return.
   task automatic do_reset();
      reset_n    = 1'b0;
      src_req    = '0;
      mcu_strobe = 1'b0;
      mcu_start  = 1'b0;
      mcu_din    = 8'h00;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_req(input logic [N-1:0] m);
      src_req = m;
      @(negedge clk);
      src_req = '0;
   endtask

   task automatic send_cmd(input logic [7:0] b, input logic [N-1:0] req);
      mcu_strobe = 1'b1;
      mcu_start  = 1'b1;
      mcu_din    = b;
      src_req    = req;
      @(negedge clk);
      mcu_strobe = 1'b0;
      mcu_start  = 1'b0;
      src_req    = '0;
   endtask

   task automatic send_data(input logic [7:0] b);
      mcu_strobe = 1'b1;
      mcu_start  = 1'b0;
      mcu_din    = b;
      @(negedge clk);
      mcu_strobe = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n got %b want 1", irq_n); end
      checks++;
      if (mcu_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", mcu_dout); end
      checks++;
      if (src_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", src_ack); end
   endtask

   task automatic test_basic();
      int bad;
      pulse_req(4'b0100);
      checks++;
      if (irq_n !== 1'b0) begin errors++; $display("FAIL basic_irq_low got %b want 0", irq_n); end
      idle(8);
      send_cmd(8'h02, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h04) begin errors++; $display("FAIL basic_pending got %h want 04", mcu_dout); end
      idle(8);
      send_cmd(8'h01, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h82) begin errors++; $display("FAIL basic_grant got %h want 82", mcu_dout); end
      checks++;
      if (src_ack !== 4'b0100) begin errors++; $display("FAIL basic_ack got %b want 0100", src_ack); end
      checks++;
      if (irq_n !== 1'b1) begin errors++; $display("FAIL basic_irq_high got %b want 1", irq_n); end
      @(negedge clk);
      checks++;
      if (src_ack !== 4'b0000) begin errors++; $display("FAIL basic_ack_drop got %b want 0000", src_ack); end
      bad = (irq_n !== 1'b1) ? 1 : 0;
      for (int k = 3; k <= 20; k++) begin
         @(negedge clk);
         if (irq_n !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL basic_holdoff irq_n low in %0d cycles want 0", bad); end
   endtask

   task automatic test_multi();
      logic [7:0]   exp_d [3];
      logic [N-1:0] exp_a [3];
      exp_d = '{8'h80, 8'h81, 8'h83};
      exp_a = '{4'b0001, 4'b0010, 4'b1000};
      do_reset();
      pulse_req(4'b1011);
      for (int i = 0; i < 3; i++) begin
         idle(8);
         send_cmd(8'h01, 4'b0000);
         checks++;
         if (mcu_dout !== exp_d[i]) begin
            errors++; $display("FAIL multi_grant%0d got %h want %h", i, mcu_dout, exp_d[i]);
         end
         checks++;
         if (src_ack !== exp_a[i]) begin
            errors++; $display("FAIL multi_ack%0d got %b want %b", i, src_ack, exp_a[i]);
         end
      end
      idle(8);
      send_cmd(8'h01, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h00) begin errors++; $display("FAIL multi_empty got %h want 00", mcu_dout); end
      checks++;
      if (src_ack !== 4'b0000) begin errors++; $display("FAIL multi_empty_ack got %b want 0000", src_ack); end
   endtask

   task automatic test_fairness();
      logic [7:0] exp;
      do_reset();
      pulse_req(4'b0010);
      idle(8);
      send_cmd(8'h01, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h81) begin errors++; $display("FAIL fair_setup got %h want 81", mcu_dout); end
      for (int i = 0; i < 4; i++) begin
         pulse_req(4'b0011);
         idle(8);
         send_cmd(8'h01, 4'b0000);
         exp = (i % 2 == 0) ? 8'h80 : 8'h81;
         checks++;
         if (mcu_dout !== exp) begin
            errors++; $display("FAIL fair_grant%0d got %h want %h", i, mcu_dout, exp);
         end
         idle(8);
      end
   endtask

   task automatic test_mask();
      do_reset();
      pulse_req(4'b0001);
      idle(8);
      send_cmd(8'h03, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h0F) begin errors++; $display("FAIL mask_read got %h want 0f", mcu_dout); end
      idle(8);
      send_data(8'h0E);
      checks++;
      if (irq_n !== 1'b1) begin errors++; $display("FAIL mask_irq_high got %b want 1", irq_n); end
      idle(8);
      send_cmd(8'h01, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h00) begin errors++; $display("FAIL mask_grant got %h want 00", mcu_dout); end
      idle(8);
      send_cmd(8'h03, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h0E) begin errors++; $display("FAIL mask_read2 got %h want 0e", mcu_dout); end
      idle(8);
      send_data(8'hFF);
      checks++;
      if (irq_n !== 1'b0) begin errors++; $display("FAIL mask_irq_low got %b want 0", irq_n); end
      idle(8);
      // Abandoned MASK_WR: a new command discards it, so the data byte is ignored.
      send_cmd(8'h03, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h0F) begin errors++; $display("FAIL mask_upper_bits got %h want 0f", mcu_dout); end
      idle(8);
      send_cmd(8'h02, 4'b0000);
      idle(8);
      send_data(8'h00);
      checks++;
      if (irq_n !== 1'b0) begin errors++; $display("FAIL mask_abandon got %b want 0", irq_n); end
   endtask

   task automatic test_same_cycle();
      int bad;
      do_reset();
      pulse_req(4'b0100);
      idle(8);
      send_cmd(8'h01, 4'b0100);
      checks++;
      if (mcu_dout !== 8'h82) begin errors++; $display("FAIL same_grant got %h want 82", mcu_dout); end
      checks++;
      if (src_ack !== 4'b0100) begin errors++; $display("FAIL same_ack got %b want 0100", src_ack); end
      bad = (irq_n !== 1'b1) ? 1 : 0;
      for (int k = 2; k <= 16; k++) begin
         @(negedge clk);
         if (irq_n !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL same_holdoff irq_n low in %0d cycles want 0", bad); end
      @(negedge clk);
      checks++;
      if (irq_n !== 1'b0) begin errors++; $display("FAIL same_irq_return got %b want 0", irq_n); end
      idle(8);
      send_cmd(8'h02, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h04) begin errors++; $display("FAIL same_pending got %h want 04", mcu_dout); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_req(4'b0001);
      idle(8);
      send_cmd(8'h01, 4'b0000);
      checks++;
      if (src_ack !== 4'b0001) begin errors++; $display("FAIL rst_pre_ack got %b want 0001", src_ack); end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (src_ack !== 4'b0000) begin errors++; $display("FAIL rst_ack_drop got %b want 0000", src_ack); end
      checks++;
      if (mcu_dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %h want 00", mcu_dout); end
      checks++;
      if (irq_n !== 1'b1) begin errors++; $display("FAIL rst_irq_n got %b want 1", irq_n); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      pulse_req(4'b0001);
      idle(8);
      send_cmd(8'h03, 4'b0000);
      idle(3);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (mcu_dout !== 8'h00) begin errors++; $display("FAIL rst_mask_dout got %h want 00", mcu_dout); end
      checks++;
      if (irq_n !== 1'b1) begin errors++; $display("FAIL rst_mask_irq got %b want 1", irq_n); end
      @(negedge clk);
      reset_n = 1'b1;
      idle(8);
      send_data(8'h00);
      idle(8);
      pulse_req(4'b0001);
      checks++;
      if (irq_n !== 1'b0) begin errors++; $display("FAIL rst_enable_kept got %b want 0", irq_n); end
      idle(8);
      send_cmd(8'h03, 4'b0000);
      checks++;
      if (mcu_dout !== 8'h0F) begin errors++; $display("FAIL rst_enable_read got %h want 0f", mcu_dout); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi();
      test_fairness();
      test_mask();
      test_same_cycle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
